// File: rtl/mem_wb_if.sv
// MEM/WB boundary bundle: MEM-stage inputs, stall/flush control and the registered WB outputs.
// The master side drives MEM and control signals; the slave side is the MEM/WB stage itself.
interface mem_wb_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 32
);
   logic              mem_valid;
   logic [DATA_W-1:0] mem_alu_result;
   logic [DATA_W-1:0] mem_read_data;
   logic              mem_to_reg;
   logic              mem_reg_write;
   logic [REG_AW-1:0] mem_write_reg;
   logic [1:0]        mem_ld_size;
   logic              mem_ld_unsigned;
   logic              stall;
   logic              flush;

   logic              wb_valid;
   logic              wb_reg_write;
   logic [REG_AW-1:0] wb_write_reg;
   logic [DATA_W-1:0] wb_write_data;
   logic              wb_misalign;
   logic [CNT_W-1:0]  retired_count;

   modport master (
      output mem_valid, mem_alu_result, mem_read_data, mem_to_reg, mem_reg_write,
             mem_write_reg, mem_ld_size, mem_ld_unsigned, stall, flush,
      input  wb_valid, wb_reg_write, wb_write_reg, wb_write_data, wb_misalign, retired_count
   );

   modport slave (
      input  mem_valid, mem_alu_result, mem_read_data, mem_to_reg, mem_reg_write,
             mem_write_reg, mem_ld_size, mem_ld_unsigned, stall, flush,
      output wb_valid, wb_reg_write, wb_write_reg, wb_write_data, wb_misalign, retired_count
   );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: load sizing/extension, mem-to-reg select, misalignment detect,
// stall/flush handling and a retired-instruction counter.
module mem_wb_stage #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   mem_wb_if.slave    bus
);

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;

   function automatic logic [31:0] fmt_load(input logic [31:0] rd, input logic [1:0] lane,
                                            input logic [1:0] sz, input logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      logic        sb;
      logic        sh;
      b = 8'h00;
      case (lane)
         2'd0:    b = rd[7:0];
         2'd1:    b = rd[15:8];
         2'd2:    b = rd[23:16];
         default: b = rd[31:24];
      endcase
      h  = lane[1] ? rd[31:16] : rd[15:0];
      sb = ~uns & b[7];
      sh = ~uns & h[15];
      case (sz)
         SZ_BYTE: fmt_load = {{24{sb}}, b};
         SZ_HALF: fmt_load = {{16{sh}}, h};
         default: fmt_load = rd;
      endcase
   endfunction

   function automatic logic is_misaligned(input logic [1:0] lane, input logic [1:0] sz);
      case (sz)
         SZ_BYTE: is_misaligned = 1'b0;
         SZ_HALF: is_misaligned = lane[0];
         default: is_misaligned = (lane != 2'b00);
      endcase
   endfunction

   logic              valid_q,     valid_d;
   logic              reg_write_q, reg_write_d;
   logic [REG_AW-1:0] write_reg_q, write_reg_d;
   logic [DATA_W-1:0] write_data_q, write_data_d;
   logic              misalign_q,  misalign_d;
   logic [CNT_W-1:0]  count_q,     count_d;

   logic              misalign;
   logic [DATA_W-1:0] load_data;

   // MEM-stage formatting, ahead of the WB register
   assign load_data = fmt_load(bus.mem_read_data, bus.mem_alu_result[1:0],
                               bus.mem_ld_size, bus.mem_ld_unsigned);
   assign misalign  = bus.mem_valid & bus.mem_to_reg &
                      is_misaligned(bus.mem_alu_result[1:0], bus.mem_ld_size);

   always_comb begin
      valid_d      = valid_q;
      reg_write_d  = reg_write_q;
      write_reg_d  = write_reg_q;
      write_data_d = write_data_q;
      misalign_d   = misalign_q;
      count_d      = count_q;
      if (bus.flush) begin
         valid_d     = 1'b0;
         reg_write_d = 1'b0;
         misalign_d  = 1'b0;
      end else if (!bus.stall) begin
         valid_d      = bus.mem_valid;
         reg_write_d  = bus.mem_valid & bus.mem_reg_write &
                        (bus.mem_write_reg != '0) & ~misalign;
         write_reg_d  = bus.mem_write_reg;
         write_data_d = bus.mem_to_reg ? load_data : bus.mem_alu_result;
         misalign_d   = misalign;
         if (bus.mem_valid && !misalign)
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // WB register stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q      <= 1'b0;
         reg_write_q  <= 1'b0;
         write_reg_q  <= '0;
         write_data_q <= '0;
         misalign_q   <= 1'b0;
         count_q      <= '0;
      end else begin
         valid_q      <= valid_d;
         reg_write_q  <= reg_write_d;
         write_reg_q  <= write_reg_d;
         write_data_q <= write_data_d;
         misalign_q   <= misalign_d;
         count_q      <= count_d;
      end
   end

   assign bus.wb_valid      = valid_q;
   assign bus.wb_reg_write  = reg_write_q;
   assign bus.wb_write_reg  = write_reg_q;
   assign bus.wb_write_data = write_data_q;
   assign bus.wb_misalign   = misalign_q;
   assign bus.retired_count = count_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: a 32-bit-counter instance plus a CNT_W=4 instance for wrap.
module tb_mem_wb_stage;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   mem_wb_if #(.DATA_W(32), .REG_AW(5), .CNT_W(32)) bus  ();
   mem_wb_if #(.DATA_W(32), .REG_AW(5), .CNT_W(4))  bus4 ();

   mem_wb_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(32)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
   mem_wb_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(4))  dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

   assign bus4.mem_valid       = bus.mem_valid;
   assign bus4.mem_alu_result  = bus.mem_alu_result;
   assign bus4.mem_read_data   = bus.mem_read_data;
   assign bus4.mem_to_reg      = bus.mem_to_reg;
   assign bus4.mem_reg_write   = bus.mem_reg_write;
   assign bus4.mem_write_reg   = bus.mem_write_reg;
   assign bus4.mem_ld_size     = bus.mem_ld_size;
   assign bus4.mem_ld_unsigned = bus.mem_ld_unsigned;
   assign bus4.stall           = bus.stall;
   assign bus4.flush           = bus.flush;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] rd,
                        input logic m2r, input logic rw, input logic [4:0] rg,
                        input logic [1:0] sz, input logic uns, input logic st, input logic fl);
      bus.mem_valid       = v;
      bus.mem_alu_result  = alu;
      bus.mem_read_data   = rd;
      bus.mem_to_reg      = m2r;
      bus.mem_reg_write   = rw;
      bus.mem_write_reg   = rg;
      bus.mem_ld_size     = sz;
      bus.mem_ld_unsigned = uns;
      bus.stall           = st;
      bus.flush           = fl;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string tag);
      check({tag, ".valid"}, {31'd0, bus.wb_valid}, 32'd0);
      check({tag, ".rw"},    {31'd0, bus.wb_reg_write}, 32'd0);
      check({tag, ".reg"},   {27'd0, bus.wb_write_reg}, 32'd0);
      check({tag, ".data"},  bus.wb_write_data, 32'd0);
      check({tag, ".mis"},   {31'd0, bus.wb_misalign}, 32'd0);
      check({tag, ".cnt"},   bus.retired_count, 32'd0);
      check({tag, ".cnt4"},  {28'd0, bus4.retired_count}, 32'd0);
   endtask

   task automatic check_wb(input string tag, input logic v, input logic rw, input logic [4:0] rg,
                           input logic [31:0] data, input logic mis, input logic [31:0] cnt);
      check({tag, ".valid"}, {31'd0, bus.wb_valid}, {31'd0, v});
      check({tag, ".rw"},    {31'd0, bus.wb_reg_write}, {31'd0, rw});
      check({tag, ".reg"},   {27'd0, bus.wb_write_reg}, {27'd0, rg});
      check({tag, ".data"},  bus.wb_write_data, data);
      check({tag, ".mis"},   {31'd0, bus.wb_misalign}, {31'd0, mis});
      check({tag, ".cnt"},   bus.retired_count, cnt);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst_n   = 1'b1;
      drive(0, 32'h0, 32'h0, 0, 0, 5'd0, 2'b10, 0, 0, 0);
      #1 rst_n = 1'b0;
      #1 check_zero("rst");
      tick();
      tick();
      rst_n = 1'b1;

      // loads: byte lane 2 signed/unsigned, half high signed, half low unsigned, byte lane 3
      drive(1, 32'h0000_1002, 32'h1280_3456, 1, 1, 5'd3, 2'b00, 0, 0, 0);
      tick(); check_wb("lb_s", 1, 1, 5'd3, 32'hFFFF_FF80, 0, 32'd1);
      drive(1, 32'h0000_1002, 32'h1280_3456, 1, 1, 5'd3, 2'b00, 1, 0, 0);
      tick(); check_wb("lb_u", 1, 1, 5'd3, 32'h0000_0080, 0, 32'd2);
      drive(1, 32'h0000_1002, 32'h8001_7FFF, 1, 1, 5'd4, 2'b01, 0, 0, 0);
      tick(); check_wb("lh_s", 1, 1, 5'd4, 32'hFFFF_8001, 0, 32'd3);
      drive(1, 32'h0000_1000, 32'h8001_7FFF, 1, 1, 5'd4, 2'b01, 1, 0, 0);
      tick(); check_wb("lh_u", 1, 1, 5'd4, 32'h0000_7FFF, 0, 32'd4);
      drive(1, 32'h0000_1003, 32'h1280_3456, 1, 1, 5'd6, 2'b00, 0, 0, 0);
      tick(); check_wb("lb3", 1, 1, 5'd6, 32'h0000_0012, 0, 32'd5);

      // misaligned half and word loads
      drive(1, 32'h0000_1001, 32'h8001_7FFF, 1, 1, 5'd4, 2'b01, 0, 0, 0);
      tick(); check_wb("lh_mis", 1, 0, 5'd4, 32'h0000_7FFF, 1, 32'd5);
      drive(1, 32'h0000_1002, 32'h8001_7FFF, 1, 1, 5'd4, 2'b10, 0, 0, 0);
      tick(); check_wb("lw_mis", 1, 0, 5'd4, 32'h8001_7FFF, 1, 32'd5);

      // ALU path, then write to $0, then a bubble
      drive(1, 32'hDEAD_BEEF, 32'h1234_5678, 0, 1, 5'd5, 2'b10, 0, 0, 0);
      tick(); check_wb("alu", 1, 1, 5'd5, 32'hDEAD_BEEF, 0, 32'd6);
      drive(1, 32'hDEAD_BEEF, 32'h1234_5678, 0, 1, 5'd0, 2'b10, 0, 0, 0);
      tick(); check_wb("alu_r0", 1, 0, 5'd0, 32'hDEAD_BEEF, 0, 32'd7);
      drive(0, 32'h0000_0004, 32'h1234_5678, 1, 1, 5'd9, 2'b10, 0, 0, 0);
      tick(); check_wb("bubble", 0, 0, 5'd9, 32'h1234_5678, 0, 32'd7);

      // stall three cycles, then release
      drive(1, 32'h1111_1111, 32'h0, 0, 1, 5'd7, 2'b10, 0, 0, 0);
      tick(); check_wb("pre_st", 1, 1, 5'd7, 32'h1111_1111, 0, 32'd8);
      drive(1, 32'h2222_2222, 32'h0, 0, 1, 5'd8, 2'b10, 0, 1, 0);
      for (int i = 0; i < 3; i++) begin
         tick(); check_wb($sformatf("stall%0d", i), 1, 1, 5'd7, 32'h1111_1111, 0, 32'd8);
      end
      bus.stall = 1'b0;
      tick(); check_wb("st_rel", 1, 1, 5'd8, 32'h2222_2222, 0, 32'd9);

      // stall+flush together, then flush clears a held misalign flag
      drive(1, 32'h3333_3333, 32'h0, 0, 1, 5'd10, 2'b10, 0, 1, 1);
      tick();
      check("sf.valid", {31'd0, bus.wb_valid}, 32'd0);
      check("sf.rw",    {31'd0, bus.wb_reg_write}, 32'd0);
      check("sf.cnt",   bus.retired_count, 32'd9);
      drive(1, 32'h0000_2002, 32'h0, 1, 1, 5'd11, 2'b10, 0, 0, 0);
      tick(); check("mis_set", {31'd0, bus.wb_misalign}, 32'd1);
      drive(1, 32'h0000_2000, 32'h0, 1, 1, 5'd11, 2'b10, 0, 0, 1);
      tick();
      check("fl.valid", {31'd0, bus.wb_valid}, 32'd0);
      check("fl.mis",   {31'd0, bus.wb_misalign}, 32'd0);
      check("fl.cnt",   bus.retired_count, 32'd9);

      // async reset mid-stream, then normal first capture
      drive(1, 32'h4444_4444, 32'h0, 0, 1, 5'd9, 2'b10, 0, 0, 0);
      tick(); check_wb("pre_rst", 1, 1, 5'd9, 32'h4444_4444, 0, 32'd10);
      #3 rst_n = 1'b0;
      #1 check_zero("rst_mid");
      #1 rst_n = 1'b1;
      drive(1, 32'h0000_0055, 32'h0, 0, 1, 5'd2, 2'b10, 0, 0, 0);
      tick(); check_wb("post_rst", 1, 1, 5'd2, 32'h0000_0055, 0, 32'd1);

      // counter wrap on the CNT_W=4 instance
      for (int i = 0; i < 14; i++) tick();
      check("cnt4_15", {28'd0, bus4.retired_count}, 32'd15);
      check("cnt_15",  bus.retired_count, 32'd15);
      tick();
      check("cnt4_wrap", {28'd0, bus4.retired_count}, 32'd0);
      check("cnt_16",    bus.retired_count, 32'd16);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
